lane_tx_serializer: RTL

- Transmit-side stage that sits directly upstream of the line-clock divider. Runs in the system clock domain.
- Accepts parallel words over a valid/ready handshake and serializes them onto up to LANES serial outputs.
- Bit periods are timed to match the divider's line-clock ratios:
  - single-lane mode: one bit per SINGLE_RATIO system clocks on lane 0;
  - multi-lane mode: bits striped across all lanes, one bit per MULTI_RATIO clocks.

---
 rtl/lane_tx_serializer.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/lane_tx_serializer.sv
// Valid/ready word serializer feeding the line-clock divider: single-lane or LANES-wide striped, LSB-first.
// Optional LANE_TX_PARITY_EN appends one even-parity bit per active lane after its data bits.
module lane_tx_serializer #(
    parameter int DATA_W       = 64,
    parameter int LANES        = 4,
    parameter int SINGLE_RATIO = 8,
    parameter int MULTI_RATIO  = 2
) (
    input  logic              clk_in,
    input  logic              rst_n,
    input  logic              single_lane,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic [LANES-1:0]  lane_data,
    output logic [LANES-1:0]  lane_en,
    output logic              bit_tick,
    output logic              busy
);

    localparam int WPL = DATA_W / LANES;
`ifdef LANE_TX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int NB_S  = DATA_W + PAR;
    localparam int NB_M  = WPL + PAR;
    localparam int MAX_R = (SINGLE_RATIO > MULTI_RATIO) ? SINGLE_RATIO : MULTI_RATIO;
    localparam int PH_W  = $clog2(MAX_R);
    localparam int BI_W  = $clog2(NB_S + 1);

    localparam logic [PH_W-1:0] PH_LAST_S = PH_W'(SINGLE_RATIO - 1);
    localparam logic [PH_W-1:0] PH_LAST_M = PH_W'(MULTI_RATIO - 1);
    localparam logic [BI_W-1:0] BI_LAST_S = BI_W'(NB_S - 1);
    localparam logic [BI_W-1:0] BI_LAST_M = BI_W'(NB_M - 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t            state_q, state_d;
    logic              mode_q, mode_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic [PH_W-1:0]   phase_q, phase_d;
    logic [BI_W-1:0]   bidx_q, bidx_d;
    logic              s_ready_q, s_ready_d;
    logic [LANES-1:0]  lane_data_q, lane_data_d;
    logic [LANES-1:0]  lane_en_q, lane_en_d;
    logic              tick_q, tick_d;
    logic              busy_q, busy_d;
    logic              accept;

    function automatic logic [PH_W-1:0] ph_last(input logic single);
        return single ? PH_LAST_S : PH_LAST_M;
    endfunction

    function automatic logic [BI_W-1:0] bi_last(input logic single);
        return single ? BI_LAST_S : BI_LAST_M;
    endfunction

`ifdef LANE_TX_PARITY_EN
    logic [LANES-1:0] par_q, par_d, par_new;

    always_comb begin
        par_new = '0;
        if (single_lane) begin
            par_new[0] = ^s_data;
        end else begin
            for (int unsigned k = 0; k < LANES; k++) begin
                for (int unsigned j = 0; j < WPL; j++) begin
                    par_new[k] = par_new[k] ^ s_data[j*LANES + k];
                end
            end
        end
    end
`endif

    assign accept = s_valid && s_ready_q;

    // Outputs are registered from the next-state values so lane_data/bit_tick/s_ready line up with the word timing.
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        shreg_d = shreg_q;
        phase_d = phase_q;
        bidx_d  = bidx_q;
        tick_d  = 1'b0;
`ifdef LANE_TX_PARITY_EN
        par_d   = par_q;
`endif
        if (state_q == SHIFT) begin
            if (phase_q == ph_last(mode_q)) begin
                phase_d = '0;
                bidx_d  = bidx_q + 1'b1;
                tick_d  = 1'b1;
                shreg_d = mode_q ? (shreg_q >> 1) : (shreg_q >> LANES);
                if (bidx_q == bi_last(mode_q)) begin
                    state_d = IDLE;
                end
            end else begin
                phase_d = phase_q + 1'b1;
            end
        end
        if (accept) begin
            state_d = SHIFT;
            mode_d  = single_lane;
            shreg_d = s_data;
            phase_d = '0;
            bidx_d  = '0;
            tick_d  = 1'b1;
`ifdef LANE_TX_PARITY_EN
            par_d   = par_new;
`endif
        end

        lane_data_d = '0;
        lane_en_d   = '0;
        busy_d      = 1'b0;
        if (state_d == SHIFT) begin
            busy_d = 1'b1;
            if (mode_d) begin
                lane_en_d[0]   = 1'b1;
                lane_data_d[0] = shreg_d[0];
            end else begin
                lane_en_d   = '1;
                lane_data_d = shreg_d[LANES-1:0];
            end
`ifdef LANE_TX_PARITY_EN
            if (bidx_d == bi_last(mode_d)) begin
                lane_data_d = par_d & lane_en_d;
            end
`endif
        end else begin
            tick_d = 1'b0;
        end
        s_ready_d = (state_d == IDLE) ||
                    ((phase_d == ph_last(mode_d)) && (bidx_d == bi_last(mode_d)));
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            mode_q      <= 1'b0;
            shreg_q     <= '0;
            phase_q     <= '0;
            bidx_q      <= '0;
            s_ready_q   <= 1'b0;
            lane_data_q <= '0;
            lane_en_q   <= '0;
            tick_q      <= 1'b0;
            busy_q      <= 1'b0;
`ifdef LANE_TX_PARITY_EN
            par_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            shreg_q     <= shreg_d;
            phase_q     <= phase_d;
            bidx_q      <= bidx_d;
            s_ready_q   <= s_ready_d;
            lane_data_q <= lane_data_d;
            lane_en_q   <= lane_en_d;
            tick_q      <= tick_d;
            busy_q      <= busy_d;
`ifdef LANE_TX_PARITY_EN
            par_q       <= par_d;
`endif
        end
    end

    assign s_ready   = s_ready_q;
    assign lane_data = lane_data_q;
    assign lane_en   = lane_en_q;
    assign bit_tick  = tick_q;
    assign busy      = busy_q;

endmodule
